// File: rtl/dma_r_sched.sv
// Round-robin scheduler feeding chunked jobs to the external->OCM DMA read engine.
// Optional request checking (req_err output) is enabled by defining DMA_R_SCHED_CHECK_EN.
module dma_r_sched #(
  parameter int NCH       = 4,
  parameter int AXI_DW    = 128,
  parameter int MAX_CHUNK = 4096,
  localparam int CH_W     = $clog2(NCH)
) (
  input  logic              usr_clk,
  input  logic              usr_reset_n,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH*32-1:0] req_src_sa,
  input  logic [NCH*32-1:0] req_dst_sa,
  input  logic [NCH*32-1:0] req_len,
  output logic [NCH-1:0]    req_done,
  output logic              cfg_valid,
  input  logic              cfg_ready,
  output logic [31:0]       cfg_src_sa,
  output logic [31:0]       cfg_dst_sa,
  output logic [31:0]       cfg_len,
  input  logic              eng_done,
  output logic              busy,
  output logic [CH_W-1:0]   cur_ch
`ifdef DMA_R_SCHED_CHECK_EN
  , output logic [NCH-1:0]  req_err
`endif
);

  localparam logic [31:0] MAX_LEN = 32'(MAX_CHUNK);

  if ((AXI_DW % 8 != 0) || (MAX_CHUNK % (AXI_DW / 8) != 0)) begin : g_bad_param
    $error("dma_r_sched: MAX_CHUNK must be a multiple of the beat size");
  end

  typedef enum logic [1:0] {IDLE, GRANT, ISSUE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] grant_nxt_ptr;
  logic            grant_found;
  logic [NCH-1:0]  grant_oh;
  logic [31:0]     grant_src, grant_dst, grant_len;
  logic [31:0]     rem_src, rem_dst, rem_len;
  logic [31:0]     chunk_len;
  logic            grant_skip;

  // First valid channel at or after the rotating pointer wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!grant_found && req_valid[(int'(rr_ptr) + i) % NCH]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'((int'(rr_ptr) + i) % NCH);
      end
    end
  end

  assign grant_oh      = NCH'(1) << grant_idx;
  assign grant_nxt_ptr = (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + 1'b1;
  assign grant_src     = req_src_sa[32*grant_idx +: 32];
  assign grant_dst     = req_dst_sa[32*grant_idx +: 32];
  assign grant_len     = req_len[32*grant_idx +: 32];
  assign chunk_len     = (rem_len > MAX_LEN) ? MAX_LEN : rem_len;

`ifdef DMA_R_SCHED_CHECK_EN
  localparam logic [31:0] B_MASK = 32'(AXI_DW / 8 - 1);
  assign grant_skip = (grant_len == '0) || ((grant_src & B_MASK) != '0) ||
                      ((grant_dst & B_MASK) != '0) || ((grant_len & B_MASK) != '0);
`else
  assign grant_skip = (grant_len == '0);
`endif

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    cfg_valid  = 1'b0;
    cfg_src_sa = '0;
    cfg_dst_sa = '0;
    cfg_len    = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (|req_valid) state_nxt = GRANT;
      end
      GRANT: begin
        if (grant_found) begin
          req_ready = grant_oh;
          state_nxt = grant_skip ? IDLE : ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        cfg_valid  = 1'b1;
        cfg_src_sa = rem_src;
        cfg_dst_sa = rem_dst;
        cfg_len    = chunk_len;
        if (cfg_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_done) state_nxt = (rem_len == '0) ? IDLE : ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request context; cur_ch returns to 0 whenever the FSM goes back to IDLE.
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      rr_ptr   <= '0;
      cur_ch   <= '0;
      rem_src  <= '0;
      rem_dst  <= '0;
      rem_len  <= '0;
      req_done <= '0;
`ifdef DMA_R_SCHED_CHECK_EN
      req_err  <= '0;
`endif
    end else begin
      req_done <= '0;
`ifdef DMA_R_SCHED_CHECK_EN
      req_err  <= '0;
`endif
      case (state)
        GRANT: begin
          if (grant_found) begin
            rem_src <= grant_src;
            rem_dst <= grant_dst;
            rem_len <= grant_len;
            rr_ptr  <= grant_nxt_ptr;
            if (grant_skip) begin
              req_done <= grant_oh;
              cur_ch   <= '0;
`ifdef DMA_R_SCHED_CHECK_EN
              req_err  <= grant_oh;
`endif
            end else begin
              cur_ch <= grant_idx;
            end
          end
        end
        ISSUE: begin
          if (cfg_ready) begin
            rem_src <= rem_src + chunk_len;
            rem_dst <= rem_dst + chunk_len;
            rem_len <= rem_len - chunk_len;
          end
        end
        WAIT: begin
          if (eng_done && (rem_len == '0)) begin
            req_done[cur_ch] <= 1'b1;
            cur_ch           <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_r_sched.sv
// Directed self-checking bench for dma_r_sched (NCH=4, 128-bit engine, 4 KiB chunks).
module tb_dma_r_sched;
  localparam int NCH = 4;

  logic              usr_clk = 1'b0;
  logic              usr_reset_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH*32-1:0] req_src_sa;
  logic [NCH*32-1:0] req_dst_sa;
  logic [NCH*32-1:0] req_len;
  logic [NCH-1:0]    req_done;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [31:0]       cfg_src_sa;
  logic [31:0]       cfg_dst_sa;
  logic [31:0]       cfg_len;
  logic              eng_done;
  logic              busy;
  logic [1:0]        cur_ch;
`ifdef DMA_R_SCHED_CHECK_EN
  logic [NCH-1:0]    req_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 usr_clk = ~usr_clk;

  dma_r_sched #(.NCH(NCH), .AXI_DW(128), .MAX_CHUNK(4096)) dut (
    .usr_clk    (usr_clk),
    .usr_reset_n(usr_reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src_sa (req_src_sa),
    .req_dst_sa (req_dst_sa),
    .req_len    (req_len),
    .req_done   (req_done),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_src_sa (cfg_src_sa),
    .cfg_dst_sa (cfg_dst_sa),
    .cfg_len    (cfg_len),
    .eng_done   (eng_done),
    .busy       (busy),
    .cur_ch     (cur_ch)
`ifdef DMA_R_SCHED_CHECK_EN
    , .req_err  (req_err)
`endif
  );

  task automatic tick;
    @(posedge usr_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [31:0] src, input logic [31:0] dst,
                               input logic [31:0] len);
    req_src_sa[32*ch +: 32] = src;
    req_dst_sa[32*ch +: 32] = dst;
    req_len[32*ch +: 32]    = len;
    req_valid[ch]           = 1'b1;
  endtask

  task automatic do_reset;
    usr_reset_n = 1'b0;
    req_valid   = '0;
    cfg_ready   = 1'b0;
    eng_done    = 1'b0;
    repeat (2) tick;
    usr_reset_n = 1'b1;
    tick;
  endtask

  // Waits for the grant, checks it went to ch, then withdraws ch once accepted.
  task automatic accept_req(input int ch);
    int n = 0;
    while (req_ready == '0 && n < 20) begin
      tick;
      n++;
    end
    checkOutput($sformatf("grant_ch%0d", ch), 32'(req_ready), 32'(1 << ch));
    tick;
    req_valid[ch] = 1'b0;
  endtask

  // One engine job: check fields, handshake, complete, check req_done.
  task automatic run_chunk(input int ch, input logic [31:0] src, input logic [31:0] dst,
                           input logic [31:0] len, input bit last);
    int n = 0;
    while (!cfg_valid && n < 20) begin
      tick;
      n++;
    end
    checkOutput("cfg_valid", 32'(cfg_valid), 32'd1);
    checkOutput("cur_ch", 32'(cur_ch), 32'(ch));
    checkOutput("cfg_src_sa", cfg_src_sa, src);
    checkOutput("cfg_dst_sa", cfg_dst_sa, dst);
    checkOutput("cfg_len", cfg_len, len);
    cfg_ready = 1'b1;
    tick;
    cfg_ready = 1'b0;
    checkOutput("cfg_valid_drop", 32'(cfg_valid), 32'd0);
    tick;
    tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    checkOutput("req_done", 32'(req_done), last ? 32'(1 << ch) : 32'd0);
  endtask

  initial begin
    req_src_sa = '0;
    req_dst_sa = '0;
    req_len    = '0;
    do_reset;

    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_req_done", 32'(req_done), 32'd0);
    checkOutput("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    checkOutput("rst_cfg_len", cfg_len, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cur_ch", 32'(cur_ch), 32'd0);

    // Single job on ch0
    applyStimulus(0, 32'h1000, 32'h0, 32'h100);
    tick;
    checkOutput("grant_busy", 32'(busy), 32'd1);
    accept_req(0);
    run_chunk(0, 32'h1000, 32'h0, 32'h100, 1'b1);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    tick;
    checkOutput("done_pulse_end", 32'(req_done), 32'd0);

    // Chunking on ch1
    applyStimulus(1, 32'h2000, 32'h8000, 32'h2810);
    accept_req(1);
    run_chunk(1, 32'h2000, 32'h8000, 32'h1000, 1'b0);
    run_chunk(1, 32'h3000, 32'h9000, 32'h1000, 1'b0);
    run_chunk(1, 32'h4000, 32'hA000, 32'h810, 1'b1);

    // Backpressure on ch2 with an early eng_done while issuing
    applyStimulus(2, 32'h5000, 32'h600, 32'h40);
    accept_req(2);
    for (int i = 0; i < 5; i++) begin
      eng_done = (i == 2);
      checkOutput("bp_cfg_valid", 32'(cfg_valid), 32'd1);
      checkOutput("bp_cfg_src", cfg_src_sa, 32'h5000);
      checkOutput("bp_cfg_len", cfg_len, 32'h40);
      tick;
    end
    eng_done  = 1'b0;
    checkOutput("bp_still_issue", 32'(cfg_valid), 32'd1);
    cfg_ready = 1'b1;
    eng_done  = 1'b1;
    tick;
    cfg_ready = 1'b0;
    eng_done  = 1'b0;
    checkOutput("bp_wait_valid", 32'(cfg_valid), 32'd0);
    tick;
    tick;
    checkOutput("bp_no_early_done", 32'(req_done), 32'd0);
    checkOutput("bp_wait_busy", 32'(busy), 32'd1);
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    checkOutput("bp_done", 32'(req_done), 32'h4);

    // Address wrap on ch3
    applyStimulus(3, 32'hFFFF_F000, 32'h10, 32'h1800);
    accept_req(3);
    run_chunk(3, 32'hFFFF_F000, 32'h10, 32'h1000, 1'b0);
    run_chunk(3, 32'h0, 32'h1010, 32'h800, 1'b1);

    // Zero length on ch0
    applyStimulus(0, 32'h100, 32'h200, 32'h0);
    accept_req(0);
    checkOutput("zero_done", 32'(req_done), 32'h1);
    checkOutput("zero_no_cfg", 32'(cfg_valid), 32'd0);
`ifdef DMA_R_SCHED_CHECK_EN
    checkOutput("zero_err", 32'(req_err), 32'h1);
`endif
    tick;

    // Misaligned length on ch2
    applyStimulus(2, 32'h7000, 32'h300, 32'h18);
`ifdef DMA_R_SCHED_CHECK_EN
    accept_req(2);
    checkOutput("chk_done", 32'(req_done), 32'h4);
    checkOutput("chk_err", 32'(req_err), 32'h4);
    checkOutput("chk_no_cfg", 32'(cfg_valid), 32'd0);
    tick;
    checkOutput("chk_no_cfg_later", 32'(cfg_valid), 32'd0);
`else
    accept_req(2);
    run_chunk(2, 32'h7000, 32'h300, 32'h18, 1'b1);
`endif

    // Reset in WAIT, then pointer must restart at ch0
    do_reset;
    applyStimulus(1, 32'h9000, 32'h0, 32'h80);
    accept_req(1);
    checkOutput("mid_cfg_valid", 32'(cfg_valid), 32'd1);
    cfg_ready = 1'b1;
    tick;
    cfg_ready   = 1'b0;
    usr_reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_cur_ch", 32'(cur_ch), 32'd0);
    checkOutput("mid_rst_cfg_valid", 32'(cfg_valid), 32'd0);
    checkOutput("mid_rst_cfg_src", cfg_src_sa, 32'd0);
    tick;
    usr_reset_n = 1'b1;
    eng_done    = 1'b1;
    tick;
    eng_done = 1'b0;
    checkOutput("mid_rst_no_done", 32'(req_done), 32'd0);
    checkOutput("mid_rst_idle", 32'(busy), 32'd0);
    applyStimulus(3, 32'hA000, 32'h0, 32'h20);
    applyStimulus(1, 32'hB000, 32'h0, 32'h30);
    accept_req(1);
    run_chunk(1, 32'hB000, 32'h0, 32'h30, 1'b1);
    accept_req(3);
    run_chunk(3, 32'hA000, 32'h0, 32'h20, 1'b1);

    // Round-robin from reset with ch0 re-requesting
    do_reset;
    for (int i = 0; i < NCH; i++)
      applyStimulus(i, 32'h1_0000 * (i + 1), 32'h100 * i, 32'h10 * (i + 1));
    accept_req(0);
    run_chunk(0, 32'h1_0000, 32'h0, 32'h10, 1'b1);
    applyStimulus(0, 32'hC000, 32'hD000, 32'h50);
    accept_req(1);
    run_chunk(1, 32'h2_0000, 32'h100, 32'h20, 1'b1);
    accept_req(2);
    run_chunk(2, 32'h3_0000, 32'h200, 32'h30, 1'b1);
    accept_req(3);
    run_chunk(3, 32'h4_0000, 32'h300, 32'h40, 1'b1);
    accept_req(0);
    run_chunk(0, 32'hC000, 32'hD000, 32'h50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
